// File: rtl/counter_checker_if.sv
// Sample/status bundle between a counter_checker and whatever feeds it.
// The master side supplies samples and the error-clear; the slave side reports status.
interface counter_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_WIDTH  = 16
);
    logic                  en;
    logic [DATA_WIDTH-1:0] din;
    logic                  clr_err;
    logic                  locked;
    logic                  error;
    logic [ERR_WIDTH-1:0]  err_count;

    modport master (output en, din, clr_err, input locked, error, err_count);
    modport slave  (input en, din, clr_err, output locked, error, err_count);
endinterface

// File: rtl/counter_checker.sv
// Receive-side checker for a wrapping counter stream: acquires lock on a run of correct
// samples, then flywheels the expected value and flags/counts every mismatch.
//
// state  | meaning
// SEARCH | resyncing to received data, counting consecutive matches toward lock
// LOCKED | flywheeling expected value, flagging mismatches, counting misses toward unlock
module counter_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int COUNT_FROM   = 0,
    parameter int COUNT_TO     = 255,
    parameter int STEP         = 1,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 4,
    parameter int ERR_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst,
    counter_checker_if.slave  bus
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t                state_q, state_d;
    logic                  seeded_q, seeded_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [MW-1:0]         match_q, match_d;
    logic [UW-1:0]         miss_q, miss_d;
    logic                  error_q, error_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;

    logic [MW-1:0]         match_inc;
    logic [UW-1:0]         miss_inc;
    logic [ERR_WIDTH-1:0]  err_base;

    // Sum is one bit wider so a step past the top of the data range is still seen as > COUNT_TO.
    function automatic logic [DATA_WIDTH-1:0] next_val(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, x} + (DATA_WIDTH+1)'(STEP);
        if (sum > (DATA_WIDTH+1)'(COUNT_TO)) next_val = DATA_WIDTH'(COUNT_FROM);
        else                                 next_val = sum[DATA_WIDTH-1:0];
    endfunction

    assign match_inc = match_q + MW'(1);
    assign miss_inc  = miss_q + UW'(1);

    always_comb begin
        state_d  = state_q;
        seeded_d = seeded_q;
        exp_d    = exp_q;
        match_d  = match_q;
        miss_d   = miss_q;
        error_d  = 1'b0;
        // Clear applies first so a same-cycle mismatch still lands as a count of one.
        err_base = bus.clr_err ? '0 : err_q;
        err_d    = err_base;

        if (bus.en) begin
            case (state_q)
                SEARCH: begin
                    exp_d = next_val(bus.din);
                    if (!seeded_q) begin
                        seeded_d = 1'b1;
                        match_d  = '0;
                    end else if (bus.din == exp_q) begin
                        match_d = match_inc;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    exp_d = next_val(exp_q);
                    if (bus.din == exp_q) begin
                        miss_d = '0;
                    end else begin
                        error_d = 1'b1;
                        if (err_base != '1) err_d = err_base + ERR_WIDTH'(1);
                        miss_d = miss_inc;
                        if (miss_inc == UW'(UNLOCK_COUNT)) begin
                            state_d  = SEARCH;
                            seeded_d = 1'b0;
                            match_d  = '0;
                            miss_d   = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEARCH;
            seeded_q <= 1'b0;
            exp_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            error_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            seeded_q <= seeded_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            error_q  <= error_d;
            err_q    <= err_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.error     = error_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_counter_checker.sv
// Randomized self-checking bench: three checker instances (default, custom wrap rule,
// narrow error counter) run against a behavioural stream model kept in the bench.
module tb_counter_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       en_v  [3];
    logic [7:0] din_v [3];
    logic       clr_v [3];
    logic        obs_l [3];
    logic        obs_e [3];
    logic [15:0] obs_c [3];

    counter_checker_if #(.DATA_WIDTH(8), .ERR_WIDTH(16)) if0 ();
    counter_checker_if #(.DATA_WIDTH(8), .ERR_WIDTH(16)) if1 ();
    counter_checker_if #(.DATA_WIDTH(8), .ERR_WIDTH(4))  if2 ();

    counter_checker u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    counter_checker #(.COUNT_FROM(10), .COUNT_TO(20), .STEP(3)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    counter_checker #(.ERR_WIDTH(4)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    assign if0.en = en_v[0];  assign if0.din = din_v[0];  assign if0.clr_err = clr_v[0];
    assign if1.en = en_v[1];  assign if1.din = din_v[1];  assign if1.clr_err = clr_v[1];
    assign if2.en = en_v[2];  assign if2.din = din_v[2];  assign if2.clr_err = clr_v[2];
    assign obs_l[0] = if0.locked;  assign obs_e[0] = if0.error;  assign obs_c[0] = if0.err_count;
    assign obs_l[1] = if1.locked;  assign obs_e[1] = if1.error;  assign obs_c[1] = if1.err_count;
    assign obs_l[2] = if2.locked;  assign obs_e[2] = if2.error;  assign obs_c[2] = {12'd0, if2.err_count};

    int total = 0;
    int bad   = 0;

    // Per-instance rule parameters and behavioural model state.
    int pf [3] = '{0, 10, 0};
    int pt [3] = '{255, 20, 255};
    int ps [3] = '{1, 3, 1};
    int pmax [3] = '{65535, 65535, 15};
    localparam int LOCKN = 4;
    localparam int UNLOCKN = 4;
    int m_locked [3];
    int m_seeded [3];
    int m_exp [3];
    int m_run [3];
    int m_err [3];
    int m_error [3];

    function automatic int mnext(int id, int x);
        int s = x + ps[id];
        return (s > pt[id]) ? pf[id] : s;
    endfunction

    task automatic model_step(int id);
        if (rst) begin
            m_locked[id] = 0; m_seeded[id] = 0; m_exp[id] = 0;
            m_run[id] = 0; m_err[id] = 0; m_error[id] = 0;
            return;
        end
        m_error[id] = 0;
        if (clr_v[id]) m_err[id] = 0;
        if (!en_v[id]) return;
        if (m_locked[id] == 0) begin
            // m_run counts consecutive matches while searching
            if (m_seeded[id] == 0) begin
                m_seeded[id] = 1;
                m_run[id] = 0;
            end else begin
                m_run[id] = (int'(din_v[id]) == m_exp[id]) ? m_run[id] + 1 : 0;
            end
            m_exp[id] = mnext(id, int'(din_v[id]));
            if (m_run[id] >= LOCKN) begin
                m_locked[id] = 1;
                m_run[id] = 0;
            end
        end else begin
            // m_run counts consecutive misses while locked
            if (int'(din_v[id]) == m_exp[id]) begin
                m_run[id] = 0;
            end else begin
                m_error[id] = 1;
                if (m_err[id] < pmax[id]) m_err[id]++;
                m_run[id]++;
            end
            m_exp[id] = mnext(id, m_exp[id]);
            if (m_run[id] >= UNLOCKN) begin
                m_locked[id] = 0;
                m_seeded[id] = 0;
                m_run[id] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
    endtask

    task automatic feed(int id, logic e, int d, logic c);
        en_v[id] = e; din_v[id] = 8'(d); clr_v[id] = c;
        cycle();
        en_v[id] = 1'b0; clr_v[id] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_l[i] !== 1'b0 || obs_e[i] !== 1'b0 || obs_c[i] !== 16'd0) begin
                bad++;
                $display("FAIL reset id=%0d got l=%b e=%b c=%0d want 0 0 0", i, obs_l[i], obs_e[i], obs_c[i]);
            end
        end
    endtask

    // Correct stream from the current value; returns enabled-sample count at which locked appeared.
    task automatic acquire(int id, inout int v, output int got);
        int n = 0;
        got = 0;
        for (int k = 0; k < 30 && got == 0; k++) begin
            feed(id, 1'b1, v, 1'b0);
            v = mnext(id, v);
            n++;
            if (obs_l[id] === 1'b1) got = n;
        end
    endtask

    task automatic test_lock_wrap(inout int v);
        int got;
        v = 0;
        acquire(0, v, got);
        total++;
        if (got != 5) begin bad++; $display("FAIL lock_latency got=%0d want=5", got); end
        for (int k = 0; k < 270; k++) begin
            feed(0, 1'b1, v, 1'b0);
            v = mnext(0, v);
            total++;
            if (obs_l[0] !== 1'b1 || obs_e[0] !== 1'b0 || obs_c[0] !== 16'd0) begin
                bad++;
                $display("FAIL wrap_run k=%0d got l=%b e=%b c=%0d want 1 0 0", k, obs_l[0], obs_e[0], obs_c[0]);
            end
        end
    endtask

    task automatic test_single_error(inout int v);
        for (int k = 0; k < 300 && v != 8'h30; k++) begin
            feed(0, 1'b1, v, 1'b0);
            v = mnext(0, v);
        end
        feed(0, 1'b1, 8'h55, 1'b0);
        v = mnext(0, v);
        total++;
        if (obs_l[0] !== 1'b1 || obs_e[0] !== 1'b1 || obs_c[0] !== 16'd1) begin
            bad++;
            $display("FAIL single_err got l=%b e=%b c=%0d want 1 1 1", obs_l[0], obs_e[0], obs_c[0]);
        end
        feed(0, 1'b1, v, 1'b0);
        v = mnext(0, v);
        total++;
        if (v != 8'h32 || obs_l[0] !== 1'b1 || obs_e[0] !== 1'b0 || obs_c[0] !== 16'd1) begin
            bad++;
            $display("FAIL flywheel got l=%b e=%b c=%0d want 1 0 1", obs_l[0], obs_e[0], obs_c[0]);
        end
    endtask

    task automatic test_unlock_relock(inout int v);
        int got;
        int c0 = m_err[0];
        for (int k = 1; k <= 4; k++) begin
            feed(0, 1'b1, v ^ 8'h80, 1'b0);
            v = mnext(0, v);
            total++;
            if (obs_e[0] !== 1'b1 || obs_l[0] !== (k < 4) || obs_c[0] !== 16'(c0 + k)) begin
                bad++;
                $display("FAIL unlock k=%0d got l=%b e=%b c=%0d want l=%0d e=1 c=%0d",
                         k, obs_l[0], obs_e[0], obs_c[0], k < 4, c0 + k);
            end
        end
        v = $urandom_range(0, 255);
        acquire(0, v, got);
        total++;
        if (got != 5) begin bad++; $display("FAIL relock got=%0d want=5", got); end
    endtask

    task automatic test_custom_rule();
        int v = 10;
        int got;
        acquire(1, v, got);
        total++;
        if (got != 5) begin bad++; $display("FAIL custom_lock got=%0d want=5", got); end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 10 && v != 10; k++) begin
                feed(1, 1'b1, v, 1'b0);
                v = mnext(1, v);
            end
            total++;
            if (obs_e[1] !== 1'b0 || obs_c[1] !== 16'(pass)) begin
                bad++;
                $display("FAIL custom_clean pass=%0d got e=%b c=%0d want 0 %0d", pass, obs_e[1], obs_c[1], pass);
            end
            feed(1, 1'b1, (pass == 0) ? 22 : 0, 1'b0);
            v = mnext(1, v);
            total++;
            if (obs_l[1] !== 1'b1 || obs_e[1] !== 1'b1 || obs_c[1] !== 16'(pass + 1)) begin
                bad++;
                $display("FAIL custom_wrap_err pass=%0d got l=%b e=%b c=%0d want 1 1 %0d",
                         pass, obs_l[1], obs_e[1], obs_c[1], pass + 1);
            end
            feed(1, 1'b1, v, 1'b0);
            v = mnext(1, v);
        end
    endtask

    task automatic test_saturate();
        int v = $urandom_range(0, 255);
        int got;
        acquire(2, v, got);
        for (int k = 0; k < 20; k++) begin
            feed(2, 1'b1, v ^ 8'hff, 1'b0);
            v = mnext(2, v);
            total++;
            if (obs_e[2] !== 1'b1 || obs_c[2] !== 16'((k + 1 > 15) ? 15 : k + 1)) begin
                bad++;
                $display("FAIL sat k=%0d got e=%b c=%0d want e=1 c=%0d", k, obs_e[2], obs_c[2], (k + 1 > 15) ? 15 : k + 1);
            end
            feed(2, 1'b1, v, 1'b0);
            v = mnext(2, v);
        end
        feed(2, 1'b1, v ^ 8'h0f, 1'b1);
        v = mnext(2, v);
        total++;
        if (obs_e[2] !== 1'b1 || obs_c[2] !== 16'd1) begin
            bad++; $display("FAIL clr_with_err got e=%b c=%0d want 1 1", obs_e[2], obs_c[2]);
        end
        feed(2, 1'b1, v, 1'b1);
        v = mnext(2, v);
        total++;
        if (obs_l[2] !== 1'b1 || obs_e[2] !== 1'b0 || obs_c[2] !== 16'd0) begin
            bad++; $display("FAIL clr_alone got l=%b e=%b c=%0d want 1 0 0", obs_l[2], obs_e[2], obs_c[2]);
        end
    endtask

    task automatic test_en_gaps_and_random(inout int v);
        int n = 0;
        int got = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        v = $urandom_range(0, 255);
        for (int k = 0; k < 100 && got == 0; k++) begin
            logic e = 1'($urandom_range(0, 1));
            feed(0, e, e ? v : 8'($urandom), 1'b0);
            if (e) begin v = mnext(0, v); n++; end
            if (obs_l[0] === 1'b1) got = n;
        end
        total++;
        if (got != 5) begin bad++; $display("FAIL gap_lock got=%0d want=5", got); end
        for (int k = 0; k < 600; k++) begin
            logic e = ($urandom_range(0, 3) != 0);
            logic c = ($urandom_range(0, 15) == 0);
            int d = ($urandom_range(0, 7) == 0) ? (v ^ $urandom_range(1, 255)) : v;
            feed(0, e, d, c);
            if (e) v = mnext(0, v);
            total++;
            if (obs_l[0] !== 1'(m_locked[0]) || obs_e[0] !== 1'(m_error[0]) || obs_c[0] !== 16'(m_err[0])) begin
                bad++;
                $display("FAIL random k=%0d got l=%b e=%b c=%0d want l=%0d e=%0d c=%0d",
                         k, obs_l[0], obs_e[0], obs_c[0], m_locked[0], m_error[0], m_err[0]);
            end
        end
    endtask

    task automatic test_reset_midlock(inout int v);
        int got;
        acquire(0, v, got);
        feed(0, 1'b1, v ^ 8'h01, 1'b0);
        v = mnext(0, v);
        rst = 1'b1;
        feed(0, 1'b1, v, 1'b0);
        rst = 1'b0;
        total++;
        if (obs_l[0] !== 1'b0 || obs_e[0] !== 1'b0 || obs_c[0] !== 16'd0) begin
            bad++; $display("FAIL rst_midlock got l=%b e=%b c=%0d want 0 0 0", obs_l[0], obs_e[0], obs_c[0]);
        end
        v = $urandom_range(0, 255);
        acquire(0, v, got);
        total++;
        if (got != 5) begin bad++; $display("FAIL rst_relock got=%0d want=5", got); end
    endtask

    initial begin
        int v = 0;
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0; din_v[i] = 8'd0; clr_v[i] = 1'b0;
            m_locked[i] = 0; m_seeded[i] = 0; m_exp[i] = 0; m_run[i] = 0; m_err[i] = 0; m_error[i] = 0;
        end
        test_reset();
        test_lock_wrap(v);
        test_single_error(v);
        test_unlock_relock(v);
        test_custom_rule();
        test_saturate();
        test_en_gaps_and_random(v);
        test_reset_midlock(v);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_checker.md
# counter_checker

Receive-side companion to the counter block. Consumes a counter sequence arriving over a link or through a datapath and checks every enabled sample against the expected next value, using the same COUNT_FROM/COUNT_TO/STEP rule. Acquires lock after a run of correct samples and flags each mismatch while locked. Keeps a saturating error count for register readout. Used in link bring-up and in-system datapath integrity tests.

## Interface
- DATA_WIDTH, 8, width of checked samples
- COUNT_FROM, 0, wrap target value
- COUNT_TO, 255, highest legal value before wrap
- STEP, 1, increment per enabled sample (≥1)
- LOCK_COUNT, 4, consecutive correct samples needed to lock (≥1)
- UNLOCK_COUNT, 4, consecutive mismatches while locked that drop lock (≥1)
- ERR_WIDTH, 16, error counter width
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  din valid this cycle
- din  in  DATA_WIDTH  received counter value
- clr_err  in  1  synchronous clear of err_count
- locked  out  1  checker is in LOCKED
- error  out  1  one-cycle pulse for a mismatch detected while locked
- err_count  out  ERR_WIDTH  saturating mismatch count

## Operation
- next(x): compute x+STEP in DATA_WIDTH+1 bits. If the sum is greater than COUNT_TO, the result is COUNT_FROM; otherwise the result is the sum. With the defaults, 255 → 0.
- Internal state: mode (SEARCH/LOCKED), seeded flag, expected[DATA_WIDTH], match_cnt, miss_cnt.
- Samples are taken only when en=1. Cycles with en=0 leave all state unchanged and give error=0.
- SEARCH, seeded=0: the sample sets expected=next(din) and seeded=1. match_cnt stays 0.
- SEARCH, seeded=1:
  - din==expected: match_cnt+1.
  - otherwise: match_cnt=0.
  - Either way, expected=next(din), so the checker resyncs to the received value.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED and set miss_cnt=0.
- LOCKED:
  - expected=next(expected) on every sample (flywheel; it does not resync to din).
  - din==expected: miss_cnt=0.
  - otherwise: error=1, err_count+1 (saturates at all-ones), miss_cnt+1.
  - When miss_cnt reaches UNLOCK_COUNT, go to SEARCH with seeded=0 and match_cnt=0.
- No errors are counted or flagged in SEARCH.
- clr_err=1 sets err_count to 0. If a mismatch occurs in the same cycle, err_count=1; the clear applies first and the new error is still counted.
- rst has priority over all inputs. After rst: mode=SEARCH, seeded=0, expected=0, match_cnt=0, miss_cnt=0. Outputs reset to locked=0, error=0, err_count=0.

## Timing
- All outputs are registered.
- A sample presented at edge N updates locked/error/err_count at edge N+1, visible in the following cycle.
- locked rises one cycle after the LOCK_COUNT-th consecutive correct sample following the seed. Total: LOCK_COUNT+1 enabled samples after reset.
- locked falls one cycle after the UNLOCK_COUNT-th consecutive miss. The error pulse for that final miss is asserted in the same cycle that locked falls.
- error is high for exactly one cycle per mismatching sample. Back-to-back mismatches give back-to-back pulses.
- Gaps in en do not break a run; only enabled samples count.
- rst mid-lock: locked=0 on the cycle after rst is sampled. Acquisition then restarts from the seed.

## Test plan
- Default params; din=0,1,2,... with en=1 every cycle → locked rises after the 5th sample (seed + 4 matches). error stays 0, err_count=0. Wrap 255→0 passes cleanly.
- Locked, then inject a single din=0x55 where 0x30 is expected, then resume the correct sequence → one error pulse, err_count=1, locked stays 1. The next sample 0x31 matches because of the flywheel.
- COUNT_FROM=10, COUNT_TO=20, STEP=3; sequence 10,13,16,19,10,13,... → locks, no errors. A 22 or a 0 instead of 10 after 19 → error.
- Locked, then four consecutive wrong values → four error pulses, err_count=4, locked falls with the 4th pulse. Correct sequence afterwards → relock after 5 samples.
- ERR_WIDTH=4; force 20 isolated mismatches while locked → err_count saturates at 15. clr_err together with a mismatch → err_count=1. clr_err alone → 0.
- en toggled 1/0 randomly over a correct sequence → identical lock timing counted in enabled samples. Assert rst for one cycle mid-lock → locked=0 and err_count=0 the next cycle, then reacquires lock.
